// File: rtl/z80_mem_responder_pkg.sv
// Shared types and constants for the Z80 memory responder.
// Optional feature macro: Z80_MEM_WAIT_EN (wait-state insertion).
package z80_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } mem_state_t;

    // Largest wait count the 3-bit wait counter can hold.
    localparam int MAX_WAIT = 7;

    // Width of the opcode-fetch counter.
    localparam int M1_CNT_W = 16;

endpackage

// File: rtl/z80_sync_ram.sv
// Byte-wide synchronous RAM: one registered read port and one write port.
// The write port is shared between the CPU bus (priority) and the side load.
module z80_sync_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [7:0]        q,
    input  logic              bus_we,
    input  logic [MEM_AW-1:0] bus_addr,
    input  logic [7:0]        bus_data,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    logic [7:0] mem [2**MEM_AW];

    // Write port: a bus write always beats a side load in the same cycle.
    always_ff @(posedge clk) begin
        if (bus_we)
            mem[bus_addr] <= bus_data;
        else if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    // Read port: q holds the last read until the next read is issued.
    always_ff @(posedge clk) begin
        if (rd_en)
            q <= mem[rd_addr];
    end

endmodule

// File: rtl/z80_mem_responder.sv
// Z80 bus memory target: decodes MREQ/RD/WR/RFSH cycles, serves reads and
// writes from an internal RAM, counts opcode fetches, flags RD+WR overlap.
// Optional feature macro: Z80_MEM_WAIT_EN -- when defined, WAIT_STATES wait
// cycles are inserted per access; otherwise every access is zero-wait.
module z80_mem_responder
    import z80_mem_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic [15:0]       addr_in,
    input  logic [7:0]        data_from_cpu,
    output logic [7:0]        data_to_cpu,
    output logic              data_oe,
    input  logic              M1_L,
    input  logic              MREQ_L,
    input  logic              IORQ_L,
    input  logic              RD_L,
    input  logic              WR_L,
    input  logic              RFSH_L,
    output logic              WAIT_L,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [15:0]       m1_count,
    output logic              proto_err
);

`ifdef Z80_MEM_WAIT_EN
    localparam int         EFF_WAIT = WAIT_STATES;
    localparam logic [2:0] WAIT_LD  = 3'(WAIT_STATES);
    logic [2:0] cnt;
`else
    localparam int EFF_WAIT = 0;
`endif

    mem_state_t        state, state_nx;
    logic              req_rd, req_wr, req_any;
    logic [MEM_AW-1:0] addr_q;
    logic              is_m1, is_wr, m1_now;
    logic              rd_en, bus_we, ld_we;
    logic [MEM_AW-1:0] rd_addr;
    logic [7:0]        ram_q;
    logic [M1_CNT_W-1:0] m1_cnt;

    // Upper address bits are ignored so memory mirrors across the 64K space.
    logic unused_bits;
    assign unused_bits = ^{addr_in[15:MEM_AW], WAIT_STATES[0]};

    // Refresh and I/O cycles never qualify as memory requests.
    assign req_rd  = !MREQ_L && !RD_L && RFSH_L && IORQ_L;
    assign req_wr  = !MREQ_L && !WR_L && RFSH_L && IORQ_L;
    assign req_any = req_rd || req_wr;

    // A fetch flag is live from the bus in IDLE, latched afterwards.
    assign m1_now = (state == IDLE) ? !M1_L : is_m1;

    // Next state and RAM strobes; RD+WR overlap falls into the read path.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = addr_in[MEM_AW-1:0];
        bus_we   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (EFF_WAIT == 0) begin
                        if (req_rd) begin
                            rd_en    = 1'b1;
                            state_nx = READ;
                        end else begin
                            state_nx = WRITE;
                        end
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
`ifdef Z80_MEM_WAIT_EN
            WAIT: begin
                if (!req_any) begin
                    state_nx = IDLE;
                end else if (cnt == 3'd1) begin
                    if (!is_wr) begin
                        rd_en    = 1'b1;
                        rd_addr  = addr_q;
                        state_nx = READ;
                    end else begin
                        state_nx = WRITE;
                    end
                end
            end
`endif
            READ: begin
                if (MREQ_L || RD_L)
                    state_nx = IDLE;
            end
            WRITE: begin
                if (!WR_L) begin
                    bus_we   = 1'b1;
                    state_nx = HOLD;
                end else begin
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                if (MREQ_L)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_L)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Capture the request context when a cycle is accepted from IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) begin
            addr_q <= addr_in[MEM_AW-1:0];
            is_m1  <= !M1_L;
            is_wr  <= !req_rd;
        end
    end

`ifdef Z80_MEM_WAIT_EN
    // Wait counter: reloaded while idle, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (!rst_L || state == IDLE)
            cnt <= WAIT_LD;
        else if (state == WAIT)
            cnt <= cnt - 3'd1;
    end
    assign WAIT_L = (state != WAIT);
`else
    assign WAIT_L = 1'b1;
`endif

    // Opcode-fetch counter bumps once on entry to READ, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_L)
            m1_cnt <= '0;
        else if (state_nx == READ && state != READ && m1_now)
            m1_cnt <= m1_cnt + 1'b1;
    end
    assign m1_count = m1_cnt;

    // Sticky flag for RD_L and WR_L both asserted during a memory request.
    always_ff @(posedge clk) begin
        if (!rst_L)
            proto_err <= 1'b0;
        else if (req_rd && !WR_L)
            proto_err <= 1'b1;
    end

    assign data_oe     = (state == READ);
    assign data_to_cpu = data_oe ? ram_q : 8'h00;
    assign ld_ready    = (state == IDLE) && !req_any;
    assign ld_we       = ld_en && ld_ready;

    z80_sync_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk      (clk),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .q        (ram_q),
        .bus_we   (bus_we),
        .bus_addr (addr_q),
        .bus_data (data_from_cpu),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

endmodule

// File: tb/tb_z80_mem_responder.sv
// Self-checking bench for z80_mem_responder with a byte-array memory model.
module tb_z80_mem_responder;
    localparam int AW = 12;
    localparam int WS = 2;
`ifdef Z80_MEM_WAIT_EN
    localparam int EXP_W = WS;
`else
    localparam int EXP_W = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_L;
    logic [15:0]   addr_in;
    logic [7:0]    data_from_cpu;
    logic [7:0]    data_to_cpu;
    logic          data_oe;
    logic          M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
    logic          WAIT_L;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic [15:0]   m1_count;
    logic          proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  model [4096];
    bit          known [4096];
    logic [11:0] kq [$];
    logic [15:0] exp_m1 = 16'h0000;

    z80_mem_responder #(.MEM_AW(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_L(rst_L), .addr_in(addr_in),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .data_oe(data_oe), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
        .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(WAIT_L),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .m1_count(m1_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic bus_idle();
        MREQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1;
        RFSH_L = 1'b1; IORQ_L = 1'b1; M1_L = 1'b1;
    endtask

    task automatic do_load(input logic [11:0] a, input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        while (!ld_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: ld_ready=%b required 1", ld_ready);
        end
        @(posedge clk);
        #1 ld_en = 1'b0;
        model[a] = d;
        if (!known[a]) kq.push_back(a);
        known[a] = 1'b1;
    endtask

    // Bus read; returns the data, cycles to data_oe, WAIT_L-low cycles and
    // whether data held a second cycle and data_oe dropped after release.
    task automatic do_read(input logic [15:0] a, input bit m1, input bit both,
                           output logic [7:0] d, output int lat,
                           output int wlow, output bit held);
        lat = 0; wlow = 0; held = 1'b1;
        @(negedge clk);
        addr_in = a; MREQ_L = 1'b0; RD_L = 1'b0; M1_L = !m1;
        if (both) begin
            WR_L = 1'b0;
            data_from_cpu = ~model[a[11:0]];
        end
        do begin
            @(negedge clk);
            lat++;
            if (!WAIT_L) wlow++;
        end while (!data_oe && lat < 20);
        d = data_to_cpu;
        @(negedge clk);
        if (data_oe !== 1'b1 || data_to_cpu !== d) held = 1'b0;
        bus_idle();
        @(negedge clk);
        if (data_oe !== 1'b0) held = 1'b0;
        if (m1) exp_m1 = exp_m1 + 16'd1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            output int oe_seen, output int wlow);
        oe_seen = 0; wlow = 0;
        @(negedge clk);
        addr_in = a; data_from_cpu = d; MREQ_L = 1'b0; WR_L = 1'b0; M1_L = 1'b1;
        for (int i = 0; i < EXP_W + 2; i++) begin
            @(negedge clk);
            if (data_oe) oe_seen++;
            if (!WAIT_L) wlow++;
        end
        bus_idle();
        @(negedge clk);
        if (data_oe) oe_seen++;
        model[a[11:0]] = d;
        if (!known[a[11:0]]) kq.push_back(a[11:0]);
        known[a[11:0]] = 1'b1;
    endtask

    task automatic test_reset();
        rst_L = 1'b0; ld_en = 1'b0; addr_in = '0; data_from_cpu = '0;
        ld_addr = '0; ld_data = '0;
        bus_idle();
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        n_chk++;
        if (WAIT_L !== 1'b1 || data_oe !== 1'b0 || data_to_cpu !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: WAIT_L=%b data_oe=%b data=%h required 1 0 00",
                     WAIT_L, data_oe, data_to_cpu);
        end
        n_chk++;
        if (m1_count !== 16'h0000 || proto_err !== 1'b0 || ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_regs: m1_count=%h proto_err=%b ld_ready=%b required 0000 0 1",
                     m1_count, proto_err, ld_ready);
        end
    endtask

    task automatic test_m1_fetch();
        logic [7:0] d; int lat, wl; bit held;
        do_load(12'h010, 8'h3C);
        do_read(16'h0010, 1'b1, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'h3C || lat != EXP_W + 1) begin
            n_fail++;
            $display("FAIL m1_fetch: data=%h lat=%0d required 3c lat=%0d", d, lat, EXP_W + 1);
        end
        n_chk++;
        if (!held) begin
            n_fail++;
            $display("FAIL m1_hold: held=%b required 1", held);
        end
        n_chk++;
        if (m1_count !== 16'h0001) begin
            n_fail++;
            $display("FAIL m1_count: got %h required 0001", m1_count);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d; int lat, wl, oe; bit held;
        do_write(16'h0123, 8'hA5, oe, wl);
        n_chk++;
        if (oe != 0 || wl != EXP_W) begin
            n_fail++;
            $display("FAIL write_oe: oe_cycles=%0d wait=%0d required 0 %0d", oe, wl, EXP_W);
        end
        do_read(16'h0123, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'hA5 || !held) begin
            n_fail++;
            $display("FAIL write_read: data=%h held=%b required a5 1", d, held);
        end
        n_chk++;
        if (m1_count !== exp_m1) begin
            n_fail++;
            $display("FAIL write_m1: m1_count=%h required %h", m1_count, exp_m1);
        end
    endtask

    task automatic test_wait();
        logic [7:0] d; int lat, wl; bit held;
        do_load(12'h040, 8'hC3);
        do_read(16'h0040, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (wl != EXP_W || lat != EXP_W + 1) begin
            n_fail++;
            $display("FAIL wait_cycles: wait_low=%0d lat=%0d required %0d %0d",
                     wl, lat, EXP_W, EXP_W + 1);
        end
        n_chk++;
        if (d !== 8'hC3) begin
            n_fail++;
            $display("FAIL wait_data: data=%h required c3", d);
        end
    endtask

    task automatic test_mirror();
        logic [7:0] d; int lat, wl, oe; bit held;
        do_write(16'h1234, 8'h55, oe, wl);
        do_read(16'h0234, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'h55) begin
            n_fail++;
            $display("FAIL mirror: data=%h required 55", d);
        end
    endtask

    task automatic test_refresh_io();
        logic [7:0] d; int lat, wl, bad; bit held;
        do_load(12'h300, 8'h11);
        bad = 0;
        @(negedge clk);
        addr_in = 16'h0300; data_from_cpu = 8'h99;
        MREQ_L = 1'b0; RFSH_L = 1'b0; WR_L = 1'b0; RD_L = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (data_oe !== 1'b0 || WAIT_L !== 1'b1 || ld_ready !== 1'b1) bad++;
        end
        bus_idle();
        IORQ_L = 1'b0; RD_L = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (data_oe !== 1'b0 || WAIT_L !== 1'b1) bad++;
        end
        bus_idle();
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL refresh_io: bad_cycles=%0d required 0", bad);
        end
        do_read(16'h0300, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'h11) begin
            n_fail++;
            $display("FAIL refresh_nowrite: data=%h required 11", d);
        end
    endtask

    task automatic test_proto_err();
        logic [7:0] d; int lat, wl; bit held;
        do_load(12'h500, 8'h77);
        n_chk++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_pre: proto_err=%b required 0", proto_err);
        end
        do_read(16'h0500, 1'b0, 1'b1, d, lat, wl, held);
        n_chk++;
        if (d !== 8'h77 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_read: data=%h proto_err=%b required 77 1", d, proto_err);
        end
        do_read(16'h0500, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'h77 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_sticky: data=%h proto_err=%b required 77 1", d, proto_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; int lat, wl; bit held;
        @(negedge clk);
        addr_in = 16'h0040; MREQ_L = 1'b0; RD_L = 1'b0; M1_L = 1'b0;
        @(negedge clk);
        rst_L = 1'b0;
        bus_idle();
        @(negedge clk);
        n_chk++;
        if (WAIT_L !== 1'b1 || data_oe !== 1'b0 || m1_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: WAIT_L=%b data_oe=%b m1_count=%h required 1 0 0000",
                     WAIT_L, data_oe, m1_count);
        end
        rst_L = 1'b1;
        exp_m1 = 16'h0000;
        do_read(16'h0123, 1'b0, 1'b0, d, lat, wl, held);
        n_chk++;
        if (d !== 8'hA5 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ram_kept: data=%h proto_err=%b required a5 0", d, proto_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] d; logic [15:0] a; logic [11:0] ka;
        int lat, wl, oe, op; bit held, m1;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 3);
            if (op == 0 || kq.size() == 0) begin
                do_load(12'($urandom), 8'($urandom));
            end else if (op == 1) begin
                a = 16'($urandom);
                do_write(a, 8'($urandom), oe, wl);
                n_chk++;
                if (oe != 0 || wl != EXP_W) begin
                    n_fail++;
                    $display("FAIL rnd_write: addr=%h oe=%0d wait=%0d required 0 %0d",
                             a, oe, wl, EXP_W);
                end
            end else begin
                ka = kq[$urandom_range(0, kq.size() - 1)];
                a = {4'($urandom), ka};
                m1 = (op == 3);
                do_read(a, m1, 1'b0, d, lat, wl, held);
                n_chk++;
                if (d !== model[ka] || lat != EXP_W + 1 || !held) begin
                    n_fail++;
                    $display("FAIL rnd_read: addr=%h data=%h lat=%0d held=%b required %h %0d 1",
                             a, d, lat, held, model[ka], EXP_W + 1);
                end
                n_chk++;
                if (m1_count !== exp_m1) begin
                    n_fail++;
                    $display("FAIL rnd_m1: m1_count=%h required %h", m1_count, exp_m1);
                end
            end
        end
    endtask

    initial begin
        rst_L = 1'b0; ld_en = 1'b0;
        bus_idle();
        test_reset();
        test_m1_fetch();
        test_write_read();
        test_wait();
        test_mirror();
        test_refresh_io();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
